dmi_core_req_ctrl: RTL and testbench



---
 rtl/dmi_pkg.sv | 20 ++
 rtl/dmi_rsp_timer.sv | 32 +++
 rtl/dmi_core_req_ctrl.sv | 117 +++++++++++
 tb/tb_dmi_core_req_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmi_pkg.sv
// DMI request controller shared types: FSM state, widths and request bundle.
// Imported by dmi_core_req_ctrl and dmi_rsp_timer.
package dmi_pkg;

  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP
  } dmi_state_e;

  typedef struct packed {
    logic                  write;
    logic [DMI_ADDR_W-1:0] addr;
    logic [DMI_DATA_W-1:0] wdata;
  } dmi_req_t;

endpackage

// File: rtl/dmi_rsp_timer.sv
// Response timeout counter: clr zeroes, en counts up.
// Ports: clk, rst_n, clr, en in; expired out (last cycle before max).
module dmi_rsp_timer #(
  parameter int TMO_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // Count reaches all-ones on the edge after this value, so the
  // timeout decision is taken on the (2^TMO_W-1)th waiting cycle.
  localparam logic [TMO_W-1:0] TMO_LAST =
    {{(TMO_W-1){1'b1}}, 1'b0};

  logic [TMO_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + TMO_W'(1);
    end
  end

  assign expired = en && (cnt_q == TMO_LAST);

endmodule

// File: rtl/dmi_core_req_ctrl.sv
// Core-side DMI request controller: one valid/ready request per access,
// response wait with timeout, held result/status and a completion toggle.
module dmi_core_req_ctrl
  import dmi_pkg::*;
#(
  parameter int ADDR_W = DMI_ADDR_W,
  parameter int DATA_W = DMI_DATA_W,
  parameter int TMO_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_en,
  input  logic              reg_wr_en,
  input  logic [ADDR_W-1:0] dmi_addr,
  input  logic [DATA_W-1:0] dmi_wdata,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata,
  input  logic              rsp_err,
  output logic [DATA_W-1:0] rdata_hold,
  output logic              err_hold,
  output logic              busy,
  output logic              done_tgl,
  output logic              overrun,
  input  logic              overrun_clr
);

  dmi_state_e state_q, state_d;
  dmi_req_t   req_q;

  logic hs;
  logic tmo;
  logic rsp_hit;

  assign hs      = (state_q == REQ) && req_ready;
  assign rsp_hit = (state_q == WAIT_RSP) && rsp_valid;

  dmi_rsp_timer #(
    .TMO_W(TMO_W)
  ) u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (hs),
    .en     (state_q == WAIT_RSP),
    .expired(tmo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (reg_en) state_d = REQ;
      REQ:      if (req_ready) state_d = WAIT_RSP;
      WAIT_RSP: if (rsp_valid || tmo) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    req_valid = 1'b0;
    busy      = 1'b0;
    if (state_q == REQ) req_valid = 1'b1;
    if (state_q != IDLE) busy = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= '0;
      rdata_hold <= '0;
      err_hold   <= 1'b0;
      done_tgl   <= 1'b0;
    end else begin
      if ((state_q == IDLE) && reg_en) begin
        req_q.write <= reg_wr_en;
        req_q.addr  <= dmi_addr;
        if (reg_wr_en) req_q.wdata <= dmi_wdata;
      end
      // A response arriving on the timeout cycle still completes normally.
      if (rsp_hit) begin
        if (!req_q.write) rdata_hold <= rsp_rdata;
        err_hold <= rsp_err;
        done_tgl <= ~done_tgl;
      end else if (tmo) begin
        if (!req_q.write) rdata_hold <= '0;
        err_hold <= 1'b1;
        done_tgl <= ~done_tgl;
      end
    end
  end

  // Set beats clear so a coincident drop is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (reg_en && (state_q != IDLE)) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  assign req_write = req_q.write;
  assign req_addr  = req_q.addr;
  assign req_wdata = req_q.wdata;

endmodule

// File: tb/tb_dmi_core_req_ctrl.sv
// Scoreboard bench for dmi_core_req_ctrl (TMO_W=3).
// Stimulus pushes expected completions; a monitor checks on done_tgl.
module tb_dmi_core_req_ctrl;

  logic        clk;
  logic        rst_n;
  logic        reg_en;
  logic        reg_wr_en;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] rdata_hold;
  logic        err_hold;
  logic        busy;
  logic        done_tgl;
  logic        overrun;
  logic        overrun_clr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sbq[$];

  dmi_core_req_ctrl #(
    .ADDR_W(7),
    .DATA_W(32),
    .TMO_W (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reg_en     (reg_en),
    .reg_wr_en  (reg_wr_en),
    .dmi_addr   (dmi_addr),
    .dmi_wdata  (dmi_wdata),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rdata_hold (rdata_hold),
    .err_hold   (err_hold),
    .busy       (busy),
    .done_tgl   (done_tgl),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done_tgl flip pops one expected completion.
  logic prev_tgl = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_tgl = 1'b0;
    end else if (done_tgl !== prev_tgl) begin
      prev_tgl = done_tgl;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got toggle, expected none");
      end else begin
        e = sbq.pop_front();
        chk("rdata_hold", 64'(rdata_hold), 64'(e.rdata));
        chk("err_hold", 64'(err_hold), 64'(e.err));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge of the first REQ cycle.
  task automatic pulse(input logic [6:0] a, input logic wr,
                       input logic [31:0] wd);
    reg_en    = 1'b1;
    reg_wr_en = wr;
    dmi_addr  = a;
    dmi_wdata = wd;
    tick();
    reg_en    = 1'b0;
    reg_wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20; i++) begin
      if (!busy) return;
      tick();
    end
    chk(name, 64'(busy), 64'd0);
  endtask

  task automatic respond(input logic [31:0] d, input logic e);
    rsp_valid = 1'b1;
    rsp_rdata = d;
    rsp_err   = e;
    tick();
    rsp_valid = 1'b0;
  endtask

  initial begin
    logic t0;
    int   k;
    rst_n = 1'b0;
    reg_en = 1'b0;
    reg_wr_en = 1'b0;
    dmi_addr = '0;
    dmi_wdata = '0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err = 1'b0;
    overrun_clr = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_outs",
        {req_valid, req_write, req_addr, busy, done_tgl, overrun,
         err_hold}, 64'd0);
    chk("reset_data", {rdata_hold, req_wdata}, 64'd0);

    // Read 0x11.
    req_ready = 1'b1;
    sbq.push_back('{32'hDEADBEEF, 1'b0});
    pulse(7'h11, 1'b0, 32'h0);
    chk("rd_req", {req_valid, req_write, req_addr}, {1'b1, 1'b0, 7'h11});
    tick();
    chk("rd_wait", {req_valid, busy}, 2'b01);
    tick();
    tick();
    respond(32'hDEADBEEF, 1'b0);
    wait_idle("rd_idle");
    chk("rd_tgl", 64'(done_tgl), 64'd1);

    // Write 0x10 with five cycles of backpressure.
    req_ready = 1'b0;
    sbq.push_back('{32'hDEADBEEF, 1'b1});
    pulse(7'h10, 1'b1, 32'h1);
    dmi_addr  = 7'h7F;
    dmi_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      chk("wr_hold", {req_valid, req_write, req_addr, req_wdata},
          {1'b1, 1'b1, 7'h10, 32'h1});
      if (i == 5) req_ready = 1'b1;
      tick();
    end
    chk("wr_acc", 64'(req_valid), 64'd0);
    tick();
    respond(32'h12345678, 1'b1);
    wait_idle("wr_idle");
    chk("wr_tgl", 64'(done_tgl), 64'd0);

    // Timeout on a read.
    sbq.push_back('{32'h0, 1'b1});
    pulse(7'h05, 1'b0, 32'h0);
    tick();
    t0 = done_tgl;
    k = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      k = i;
      if (done_tgl !== t0) break;
    end
    chk("tmo_latency", 64'(k), 64'd7);
    chk("tmo_busy", 64'(busy), 64'd0);

    // Overrun while waiting for a response.
    sbq.push_back('{32'hCAFEF00D, 1'b0});
    pulse(7'h22, 1'b0, 32'h0);
    tick();
    reg_en = 1'b1;
    tick();
    reg_en = 1'b0;
    chk("ovr_set", {overrun, req_valid}, 2'b10);
    reg_en = 1'b1;
    overrun_clr = 1'b1;
    tick();
    reg_en = 1'b0;
    overrun_clr = 1'b0;
    chk("ovr_set_wins", 64'(overrun), 64'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_clr", 64'(overrun), 64'd0);
    respond(32'hCAFEF00D, 1'b0);
    wait_idle("ovr_idle");
    tick();
    chk("ovr_no_req", {req_valid, busy}, 2'b00);

    // Reset in the middle of a request.
    req_ready = 1'b0;
    pulse(7'h33, 1'b0, 32'h0);
    chk("rst_req", 64'(req_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async",
        {req_valid, req_write, req_addr, busy, done_tgl, overrun,
         err_hold}, 64'd0);
    chk("rst_async_data", {rdata_hold, req_wdata}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    req_ready = 1'b1;
    tick();
    sbq.push_back('{32'hA5A5A5A5, 1'b0});
    pulse(7'h33, 1'b0, 32'h0);
    chk("rst_rd_req", {req_valid, req_addr}, {1'b1, 7'h33});
    tick();
    tick();
    respond(32'hA5A5A5A5, 1'b0);
    wait_idle("rst_rd_idle");

    // Stray response in IDLE is ignored.
    tick();
    t0 = done_tgl;
    respond(32'hFFFF_FFFF, 1'b1);
    tick();
    chk("stray", {done_tgl, err_hold, busy}, {t0, 1'b0, 1'b0});

    // Response coincident with the timeout cycle wins.
    sbq.push_back('{32'h0BADF00D, 1'b0});
    pulse(7'h44, 1'b0, 32'h0);
    tick();
    repeat (6) tick();
    respond(32'h0BADF00D, 1'b0);
    chk("coinc_busy", 64'(busy), 64'd0);
    wait_idle("coinc_idle");
    repeat (2) tick();

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
